// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port RAM.
// Port 0 is the core, port 1 the loader/debug port. Accesses are fully
// serialised: grant, one RAM cycle, then a completion pulse.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
// until gntN pulses for one cycle. The operands are captured on that edge
// and req may then drop. doneN pulses exactly once per granted access;
// rdataN and errN are meaningful only in that done cycle and read 0 at
// every other time. A request that shows up while an access is in flight
// waits until the arbiter is idle again.
module mem_arbiter #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              err0,
  output logic              err1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                last_q;   // port granted most recently
  logic                port_q;   // port owning the in-flight access
  logic                we_q;
  logic                mis_q;    // in-flight access is misaligned
  logic [RAM_AW-1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic                any_req;
  logic                win;
  logic                grant;
  logic                sel_we;
  logic [RAM_AW-1:0]   sel_idx;
  logic [1:0]          sel_lo;
  logic [31:0]         sel_wdata;
  logic                sel_mis;
  logic                resp_rd;

  // Address bits above the RAM index wrap onto the RAM and are not used.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{addr0[31:RAM_AW+2], addr1[31:RAM_AW+2]};

  assign dbg_state = state_q;

  // Round-robin winner selection and operand mux for the winning port.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win = ~last_q;
    else              win = ~req0;
    grant     = (state_q == S_IDLE) && any_req && !rst;
    sel_we    = win ? we1 : we0;
    sel_idx   = win ? addr1[RAM_AW+1:2] : addr0[RAM_AW+1:2];
    sel_lo    = win ? addr1[1:0] : addr0[1:0];
    sel_wdata = win ? wdata1 : wdata0;
    sel_mis   = |sel_lo;
  end

  // Next-state logic: misaligned accesses skip the RAM cycle entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = sel_mis ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: grants in IDLE, RAM strobe in ACCESS, completion in RESP.
  always_comb begin
    gnt0      = grant && !win;
    gnt1      = grant && win;
    ram_en    = (state_q == S_ACCESS);
    ram_we    = ram_en && we_q;
    ram_addr  = ram_en ? addr_q : '0;
    ram_wdata = ram_en ? wdata_q : '0;
    done0     = (state_q == S_RESP) && !port_q;
    done1     = (state_q == S_RESP) && port_q;
    err0      = done0 && mis_q;
    err1      = done1 && mis_q;
    resp_rd   = !we_q && !mis_q;
    rdata0    = (done0 && resp_rd) ? ram_rdata : '0;
    rdata1    = (done1 && resp_rd) ? ram_rdata : '0;
  end

  // State register and capture of the granted request's operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q  <= win;
        port_q  <= win;
        we_q    <= sel_we;
        mis_q   <= sel_mis;
        addr_q  <= sel_idx;
        wdata_q <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic on both ports,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int RAM_AW = 10;
  localparam int DEPTH  = 1 << RAM_AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req   [2];
  logic              we    [2];
  logic [31:0]       addr  [2];
  logic [31:0]       wdata [2];
  logic              gnt   [2];
  logic              done  [2];
  logic [31:0]       rdata [2];
  logic              err   [2];
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [1:0]        dbg_state;

  mem_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .done0(done[0]), .done1(done[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]), .err0(err[0]), .err1(err[1]),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Synchronous single-port RAM: read data appears the cycle after ram_en.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_until = 0;          // first cycle the arbiter can grant again
  int last_w   = 1;
  bit          out_valid = 0;
  int          out_port, out_gnt_cyc;
  bit          out_we, out_mis;
  int          out_idx;
  logic [31:0] out_wdata;
  logic [31:0] ref_mem [DEPTH];
  bit          hold_mode = 0;
  bit          drop_req [2];
  bit          seen_done [2];
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  int          ram_en_count = 0;
  logic [RAM_AW-1:0] last_ram_addr;
  int          gnt_port_log[$];
  int          gnt_cyc_log[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Compare every DUT output against the transaction model for this cycle.
  task automatic monitor();
    bit          exp_en, dn, mine;
    logic [31:0] exp_rd;
    int          win;
    bit          g [2];
    exp_en = out_valid && !out_mis && (cyc == out_gnt_cyc + 1);
    check("ram_en", ram_en, exp_en);
    check("ram_we", ram_we, exp_en ? out_we : 1'b0);
    if (exp_en) begin
      check("ram_addr", ram_addr, out_idx);
      if (out_we) check("ram_wdata", ram_wdata, out_wdata);
    end
    if (ram_en) begin
      ram_en_count++;
      last_ram_addr = ram_addr;
    end
    dn = out_valid && (cyc == out_gnt_cyc + (out_mis ? 1 : 2));
    exp_rd = (dn && !out_we && !out_mis) ? ref_mem[out_idx] : 32'h0;
    for (int p = 0; p < 2; p++) begin
      mine = dn && (out_port == p);
      check($sformatf("done%0d", p), done[p], mine);
      check($sformatf("err%0d", p), err[p], mine && out_mis);
      check($sformatf("rdata%0d", p), rdata[p], mine ? exp_rd : 32'h0);
      if (done[p]) begin
        seen_done[p]  = 1;
        last_rdata[p] = rdata[p];
        last_err[p]   = err[p];
      end
    end
    if (dn) begin
      if (out_we && !out_mis) ref_mem[out_idx] = out_wdata;
      out_valid = 0;
    end
    g[0] = 0;
    g[1] = 0;
    win  = -1;
    if (cyc >= busy_until && (req[0] || req[1])) begin
      if (req[0] && req[1]) win = 1 - last_w;
      else                  win = req[0] ? 0 : 1;
      g[win] = 1;
    end
    check("gnt0", gnt[0], g[0]);
    check("gnt1", gnt[1], g[1]);
    if (win >= 0) begin
      out_valid   = 1;
      out_port    = win;
      out_gnt_cyc = cyc;
      out_we      = we[win];
      out_mis     = (addr[win] % 4) != 0;
      out_idx     = idx_of(addr[win]);
      out_wdata   = wdata[win];
      last_w      = win;
      busy_until  = cyc + (out_mis ? 2 : 3);
      gnt_port_log.push_back(win);
      gnt_cyc_log.push_back(cyc);
      if (!hold_mode) drop_req[win] = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (drop_req[p]) req[p] = 1'b0;
      drop_req[p] = 0;
    end
  endtask

  task automatic issue(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[p]       = 1'b1;
    we[p]        = w;
    addr[p]      = a;
    wdata[p]     = d;
    seen_done[p] = 0;
  endtask

  task automatic wait_done(input int p);
    for (int i = 0; i < 12 && !seen_done[p]; i++) run_cycle();
    check($sformatf("done%0d_timeout", p), seen_done[p], 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    out_valid = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ctrl", {gnt[0], gnt[1], done[0], done[1], err[0], err[1], ram_en, ram_we}, 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_rdata0", rdata[0], 32'h0);
      check("rst_rdata1", rdata[1], 32'h0);
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    last_w = 1;
    busy_until = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0;
      drop_req[p] = 0; seen_done[p] = 0;
    end
    @(negedge clk);
    req[0] = 1'b1;                      // grant must stay low while in reset
    do_reset(3);
    req[0] = 1'b0;

    // Port 0 write, then port 1 read-back of the same word.
    ram_en_count = 0;
    issue(0, 1, 32'h1000_0000, 32'h0000_000A);
    wait_done(0);
    check("w0_err", last_err[0], 1'b0);
    check("w0_ram_addr", last_ram_addr, 32'h0);
    check("w0_ram_en_cnt", ram_en_count, 1);
    issue(1, 0, 32'h1000_0000, 32'h0);
    wait_done(1);
    check("r1_rdata", last_rdata[1], 32'h0000_000A);
    check("r1_err", last_err[1], 1'b0);

    // Both ports held high: alternating grants three cycles apart.
    hold_mode = 1;
    gnt_port_log.delete();
    gnt_cyc_log.delete();
    issue(0, 0, 32'h1000_0010, 32'h0);
    issue(1, 0, 32'h1000_0020, 32'h0);
    for (int i = 0; i < 20 && gnt_port_log.size() < 4; i++) run_cycle();
    hold_mode = 0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    check("rr_count", gnt_port_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_port_log.size(); i++) begin
      check($sformatf("rr_order%0d", i), gnt_port_log[i], exp_q[i]);
      if (i > 0) check($sformatf("rr_space%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], 3);
    end

    // Misaligned read: error, zero data, no RAM strobe.
    ram_en_count = 0;
    issue(0, 0, 32'h1000_0006, 32'h0);
    wait_done(0);
    check("mis_err", last_err[0], 1'b1);
    check("mis_rdata", last_rdata[0], 32'h0);
    check("mis_ram_en_cnt", ram_en_count, 0);

    // Reset during the RAM cycle of a port 1 write must abort it cleanly.
    issue(1, 1, 32'h1000_0040, 32'h0000_5555);
    wait_done(1);
    issue(1, 1, 32'h1000_0040, 32'h0000_DEAD);
    gnt_port_log.delete();
    for (int i = 0; i < 6 && gnt_port_log.size() == 0; i++) run_cycle();
    check("abort_granted", gnt_port_log.size(), 1);
    seen_done[1] = 0;
    do_reset(2);
    for (int i = 0; i < 3; i++) run_cycle();
    check("abort_no_done", seen_done[1], 1'b0);
    issue(1, 0, 32'h1000_0040, 32'h0);
    wait_done(1);
    check("abort_ram_kept", last_rdata[1], 32'h0000_5555);

    // Upper address bits wrap onto the RAM.
    issue(1, 0, 32'h1000_1004, 32'h0);
    wait_done(1);
    check("wrap_ram_addr", last_ram_addr, 32'h1);

    // Randomized traffic from both ports.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          logic [31:0] a;
          a = ($urandom << 12) | (32'($urandom_range(0, 31)) << 2);
          if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
          issue(p, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      run_cycle();
    end
    for (int i = 0; i < 20 && (req[0] || req[1]); i++) run_cycle();
    check("drain_req", {req[0], req[1]}, 32'h0);
    for (int i = 0; i < 4; i++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAM_AW, default 10, word-address width of the shared RAM; the RAM index is addr[RAM_AW+1:2].
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0, req1  in  1 each  access request; port 0 = core, port 1 = loader/debug.
REQ-005 we0, we1  in  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  in  32 each  byte address.
REQ-007 wdata0, wdata1  in  32 each  write data.
REQ-008 gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, address/data latched.
REQ-009 done0, done1  out  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  out  32 each  read data; valid only while the matching done is high.
REQ-011 err0, err1  out  1 each  high with done when the access was misaligned.
REQ-012 ram_en, ram_we  out  1 each  RAM access strobe and write enable.
REQ-013 ram_addr  out  RAM_AW  RAM word address.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_rdata  in  32  RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-016 FSM states IDLE, ACCESS, RESP.
REQ-017 IDLE: if any req is high, pick a winner, pulse its gnt, and latch we, addr, wdata and port id; then go to ACCESS, or to RESP if the access is misaligned.
REQ-018 Arbitration is round-robin: on simultaneous req0 and req1, the port not granted last wins; last_winner resets to port 1, so port 0 wins the first tie.
REQ-019 A lone requester is granted in the same cycle it is observed in IDLE, regardless of last_winner.
REQ-020 ACCESS: ram_en=1 for exactly one cycle, with ram_we, ram_addr and ram_wdata from the latched values; next state RESP.
REQ-021 RESP: pulse done on the latched port; for reads, drive rdata from ram_rdata; next state IDLE.
REQ-022 Misaligned access (addr[1:0] != 0): no RAM strobe, err=1 with done, rdata=0, and RAM contents unchanged.
REQ-023 Latency: gnt at cycle T, ram_en at T+1, done at T+2; back-to-back throughput is one access per 3 cycles.
REQ-024 Requesters hold req and operands until gnt; req may drop after gnt and is ignored until the next IDLE.
REQ-025 A req asserted during ACCESS or RESP is not granted until the FSM returns to IDLE.
REQ-026 rdata of the non-completing port, and of any port outside its done cycle, reads 0.
REQ-027 ram_we=0 whenever ram_en=0, and gnt/done/err are never high on both ports in the same cycle.
REQ-028 Address bits above RAM_AW+1 are ignored (wrap-around onto the RAM).

Reset
REQ-029 While rst is high: state=IDLE, last_winner=1, and all gnt, done, err, ram_en, ram_we outputs are 0; ram_addr, ram_wdata and rdata are 0.
REQ-030 Reset asserted mid-operation aborts the access, produces no done, and leaves the RAM untouched if rst arrives before the ACCESS edge.
REQ-031 After rst falls, the first grant is issued no earlier than the first rising edge with rst low.

Verification
REQ-032 After reset, port 0 writes 0x0000000A to 0x10000000 -> gnt0 at T, ram_en=1/ram_we=1 at T+1 with ram_addr=0x000, done0 at T+2.
REQ-033 Port 1 reads 0x10000000 after that write -> done1 with rdata1=0x0000000A and err1=0.
REQ-034 req0 and req1 held high continuously for 4 grants -> grant order 0,1,0,1 with 3-cycle spacing, and never both gnt in the same cycle.
REQ-035 Port 0 reads 0x10000006 -> done0 with err0=1, rdata0=0, no ram_en pulse.
REQ-036 rst pulsed during ACCESS of a port 1 write -> no done1, and all outputs 0 while rst is high.
REQ-037 Port 1 reads address 0x10001004 -> ram_addr=0x001 (upper bits ignored).
